// File: rtl/serializer_fifo_if.sv
// Handshake bundle between an upstream word source, the serializer and the downstream chunk sink.
// The slave modport is the serializer's view; the master modport is the surrounding logic's view.
interface serializer_fifo_if #(
   parameter int unsigned G_OUT_SIZE = 8,
   parameter int unsigned G_RATIO    = 4
);
   localparam int unsigned IW = G_OUT_SIZE * G_RATIO;
   localparam int unsigned CW = $clog2(G_RATIO) + 1;

   logic                  s_valid_i;
   logic                  s_ready_o;
   logic [IW-1:0]         s_data_i;
   logic [CW-1:0]         s_count_i;
   logic                  m_valid_o;
   logic                  m_ready_i;
   logic [G_OUT_SIZE-1:0] m_data_o;
   logic                  m_last_o;

   modport slave (
      input  s_valid_i,
      input  s_data_i,
      input  s_count_i,
      input  m_ready_i,
      output s_ready_o,
      output m_valid_o,
      output m_data_o,
      output m_last_o
   );

   modport master (
      output s_valid_i,
      output s_data_i,
      output s_count_i,
      output m_ready_i,
      input  s_ready_o,
      input  m_valid_o,
      input  m_data_o,
      input  m_last_o
   );
endinterface

// File: rtl/serializer_fifo.sv
// Wide-to-narrow serializer: one word per input handshake, emitted LSB-first as up to G_RATIO
// chunks with a last flag; a new word may load in the last-chunk cycle so output has no bubbles.
module serializer_fifo #(
   parameter int unsigned G_OUT_SIZE = 8,
   parameter int unsigned G_RATIO    = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   serializer_fifo_if.slave  bus
);
   localparam int unsigned IW = G_OUT_SIZE * G_RATIO;
   localparam int unsigned CW = $clog2(G_RATIO) + 1;

   logic [IW-1:0] sh_q, sh_d;
   logic [CW-1:0] rem_q, rem_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] cnt_eff;
   logic          last;
   logic          s_ready;
   logic          in_hs;
   logic          out_hs;

   assign last    = valid_q && (rem_q == CW'(1));
   // Combinational from m_ready_i so the next word can load in the final-chunk cycle.
   assign s_ready = !valid_q || (bus.m_ready_i && last);
   assign in_hs   = bus.s_valid_i && s_ready;
   assign out_hs  = valid_q && bus.m_ready_i;

   assign bus.s_ready_o = s_ready;
   assign bus.m_valid_o = valid_q;
   assign bus.m_data_o  = sh_q[G_OUT_SIZE-1:0];
   assign bus.m_last_o  = last;

   always_comb begin
      cnt_eff = bus.s_count_i;
      if ((bus.s_count_i == '0) || (bus.s_count_i > CW'(G_RATIO))) begin
         cnt_eff = CW'(G_RATIO);
      end

      sh_d    = sh_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      if (in_hs) begin
         sh_d    = bus.s_data_i;
         rem_d   = cnt_eff;
         valid_d = 1'b1;
      end else if (out_hs) begin
         if (rem_q > CW'(1)) begin
            sh_d  = sh_q >> G_OUT_SIZE;
            rem_d = rem_q - CW'(1);
         end else begin
            valid_d = 1'b0;
            rem_d   = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh_q    <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: tb/tb_serializer_fifo.sv
// Self-checking bench for serializer_fifo: word table plus hand sequences, with a chunk
// scoreboard fed at stimulus time and drained by an output-handshake monitor.
module tb_serializer_fifo;
   localparam int unsigned OS = 8;
   localparam int unsigned RT = 4;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  count;
      int          n_exp;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   hs_cnt;
   bit   mon_en;
   exp_t exp_q[$];
   vec_t vecs[6];

   serializer_fifo_if #(.G_OUT_SIZE(OS), .G_RATIO(RT)) bus ();

   serializer_fifo #(.G_OUT_SIZE(OS), .G_RATIO(RT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s act=%0h req=%0h", name, act, req);
      end
   endtask

   // Drive one word, queue its expected chunks, return the number of edges until accepted.
   task automatic send_word(input logic [31:0] data, input logic [2:0] count, input int n_exp,
                            output int waited);
      bit acc;
      bit ok;
      logic [31:0] tmp;
      tmp = data;
      for (int k = 0; k < n_exp; k++) begin
         exp_q.push_back('{data: tmp[7:0], last: (k == n_exp - 1)});
         tmp = tmp >> 8;
      end
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = data;
      bus.s_count_i = count;
      waited = 0;
      ok = 1'b0;
      while (!ok && waited < 20) begin
         @(negedge clk);
         acc = (bus.s_ready_o === 1'b1) && !rst;
         @(posedge clk);
         #1;
         waited++;
         if (acc) ok = 1'b1;
      end
      bus.s_valid_i = 1'b0;
      chk("accept_timeout", {31'd0, ok}, 32'd1);
      chk("first_chunk_valid", {31'd0, bus.m_valid_o}, 32'd1);
      chk("first_chunk_data", {24'd0, bus.m_data_o}, {24'd0, data[7:0]});
      chk("first_chunk_last", {31'd0, bus.m_last_o}, {31'd0, (n_exp == 1)});
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", {31'd0, (exp_q.size() == 0)}, 32'd1);
      @(posedge clk);
      #1;
      chk("idle_after_drain", {31'd0, bus.m_valid_o}, 32'd0);
   endtask

   initial begin
      int w;
      int hs0;
      checks   = 0;
      failures = 0;
      hs_cnt   = 0;
      mon_en   = 1'b0;
      vecs[0] = '{data: 32'h44332211, count: 3'd4, n_exp: 4};
      vecs[1] = '{data: 32'hAABBCCDD, count: 3'd2, n_exp: 2};
      vecs[2] = '{data: 32'h12345678, count: 3'd0, n_exp: 4};
      vecs[3] = '{data: 32'h9ABCDEF0, count: 3'd7, n_exp: 4};
      vecs[4] = '{data: 32'h55667788, count: 3'd1, n_exp: 1};
      vecs[5] = '{data: 32'h0BADF00D, count: 3'd3, n_exp: 3};

      // Scoreboard monitor: every output handshake pops one expected chunk.
      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (mon_en && !rst && bus.m_valid_o === 1'b1 && bus.m_ready_i === 1'b1) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_chunk act=%0h req=none", bus.m_data_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("chunk_data", {24'd0, bus.m_data_o}, {24'd0, e.data});
                  chk("chunk_last", {31'd0, bus.m_last_o}, {31'd0, e.last});
               end
            end
         end
      join_none

      // Reset: two cycles, with a word offered during the second.
      rst = 1'b1;
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = '0;
      bus.s_count_i = '0;
      bus.m_ready_i = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, bus.m_valid_o}, 32'd0);
      chk("rst_data", {24'd0, bus.m_data_o}, 32'd0);
      chk("rst_last", {31'd0, bus.m_last_o}, 32'd0);
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 32'hDEADBEEF;
      bus.s_count_i = 3'd4;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.s_valid_i = 1'b0;
      chk("rst_ready_after", {31'd0, bus.s_ready_o}, 32'd1);
      chk("rst_word_dropped", {31'd0, bus.m_valid_o}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_still_idle", {31'd0, bus.m_valid_o}, 32'd0);
      mon_en = 1'b1;

      // Table: each word from idle with m_ready held high.
      for (int i = 0; i < 6; i++) begin
         hs0 = hs_cnt;
         send_word(vecs[i].data, vecs[i].count, vecs[i].n_exp, w);
         chk("tbl_latency", w, 1);
         for (int k = 0; k < vecs[i].n_exp; k++) begin
            @(negedge clk);
            chk("tbl_s_ready", {31'd0, bus.s_ready_o}, {31'd0, (k == vecs[i].n_exp - 1)});
            chk("tbl_last", {31'd0, bus.m_last_o}, {31'd0, (k == vecs[i].n_exp - 1)});
            @(posedge clk);
            #1;
         end
         chk("tbl_idle", {31'd0, bus.m_valid_o}, 32'd0);
         chk("tbl_chunk_count", hs_cnt - hs0, vecs[i].n_exp);
      end

      // Backpressure on chunk 1.
      send_word(32'h44332211, 3'd4, 4, w);
      @(posedge clk);
      #1;
      bus.m_ready_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_data", {24'd0, bus.m_data_o}, 32'h22);
         chk("bp_valid", {31'd0, bus.m_valid_o}, 32'd1);
         chk("bp_s_ready", {31'd0, bus.s_ready_o}, 32'd0);
         @(posedge clk);
         #1;
      end
      bus.m_ready_i = 1'b1;
      wait_drain();

      // Back-to-back words: second one loads in the 0x04 cycle with no bubble.
      hs0 = hs_cnt;
      send_word(32'h04030201, 3'd4, 4, w);
      send_word(32'h08070605, 3'd4, 4, w);
      chk("b2b_accept_cycle", w, 4);
      wait_drain();
      chk("b2b_chunk_count", hs_cnt - hs0, 8);

      // Reset after chunk 0x22 has been accepted.
      send_word(32'h44332211, 3'd4, 4, w);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("mid_shows_33", {24'd0, bus.m_data_o}, 32'h33);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_valid", {31'd0, bus.m_valid_o}, 32'd0);
      repeat (5) begin
         @(negedge clk);
         chk("mid_rst_stays_idle", {31'd0, bus.m_valid_o}, 32'd0);
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
